// File: rtl/md_sched_if.sv
// md_sched_if: issue/operand bundle and HI/LO result view for the multiply-divide scheduler
interface md_sched_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master(output start, op, a, b, md_use, input busy, stall, hi, lo);
   modport slave(input start, op, a, b, md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply-divide unit with a fixed-latency busy window and ID-stage stall
module md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input logic       clk,
   input logic       rst_n,
   md_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   localparam logic [3:0] MUL_CNT = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [31:0] hi, lo, dvs, q_s, r_s;
   logic [63:0] res, prod, quot_rem;
   logic idle, md_op, ovf, done;
   assign idle  = state == IDLE;
   assign md_op = bus.start & ~bus.op[2];
   assign ovf   = ~bus.op[0] & (bus.a == 32'h8000_0000) & (bus.b == 32'hFFFF_FFFF);
   // Dividing by 1 in the overflow case yields exactly the required 8000_0000 / 0 result
   assign dvs   = (ovf || bus.b == 32'h0) ? 32'd1 : bus.b;
   assign q_s   = $signed(bus.a) / $signed(dvs);
   assign r_s   = $signed(bus.a) % $signed(dvs);
   assign prod  = bus.op[0] ? {32'h0, bus.a} * {32'h0, bus.b}
                            : $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
   assign quot_rem = bus.b == 32'h0 ? {bus.a, 32'hFFFF_FFFF}
                   : bus.op[0]      ? {bus.a % dvs, bus.a / dvs}
                                    : {r_s, q_s};
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done    = 1'b0;
      if (idle) begin
         if (md_op) begin
            state_n = bus.op[1] ? DIV : MUL;
            cnt_n   = bus.op[1] ? DIV_CNT : MUL_CNT;
         end
      end else if (cnt == 4'd0) begin
         state_n = IDLE;
         done    = 1'b1;
      end else begin
         cnt_n = cnt - 4'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         res   <= 64'h0;
         hi    <= 32'h0;
         lo    <= 32'h0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (idle && md_op) res <= bus.op[1] ? quot_rem : prod;
         if (done) {hi, lo} <= res;
         else if (idle && bus.start && bus.op == 3'b100) hi <= bus.a;
         else if (idle && bus.start && bus.op == 3'b101) lo <= bus.a;
      end
   end
   assign bus.busy  = ~idle;
   assign bus.stall = bus.md_use & (~idle | md_op);
   assign bus.hi    = hi;
   assign bus.lo    = lo;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and randomized checks of md_sched against a deadline-based reference model
module tb_md_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   md_sched_if bus();
   md_sched dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int m_end = 0;
   logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
   logic [63:0] m_res = 64'h0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask
   // Result as {HI, LO} computed with wide integer arithmetic
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      logic [63:0] ux, uy, qq, rr;
      if (o == 3'd0) begin
         q = longint'($signed(a)) * longint'($signed(b));
         return q;
      end
      if (o == 3'd1) begin
         ux = {32'h0, a};
         uy = {32'h0, b};
         return ux * uy;
      end
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (o == 3'd2) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
         q = x / y;
         r = x - q * y;
      end else begin
         ux = {32'h0, a};
         uy = {32'h0, b};
         q = longint'(ux / uy);
         r = longint'(ux % uy);
      end
      qq = q;
      rr = r;
      return {rr[31:0], qq[31:0]};
   endfunction
   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction
   task automatic cycle(input logic st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mdu, input logic rn);
      bus.start = st;
      bus.op = o;
      bus.a = a;
      bus.b = b;
      bus.md_use = mdu;
      rst_n = rn;
      #1;
      chk("stall", bus.stall, mdu & ((cyc < m_end) | (st & ~o[2])));
      @(posedge clk);
      cyc++;
      if (!rn) begin
         m_hi = 32'h0;
         m_lo = 32'h0;
         m_end = 0;
      end else if (cyc - 1 < m_end) begin
         if (cyc == m_end) {m_hi, m_lo} = m_res;
      end else if (st && !o[2]) begin
         m_res = ref_res(o, a, b);
         m_end = cyc + (o[1] ? 10 : 5);
      end else if (st && o == 3'd4) begin
         m_hi = a;
      end else if (st && o == 3'd5) begin
         m_lo = a;
      end
      #1;
      chk("busy", bus.busy, cyc < m_end);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
   endtask
   task automatic idle(input int n, input logic mdu);
      repeat (n) cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, mdu, 1'b1);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.op = 3'd0;
      bus.a = 32'h0;
      bus.b = 32'h0;
      bus.md_use = 1'b0;
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("rst_hi", bus.hi, 64'h0);
      chk("rst_lo", bus.lo, 64'h0);
      chk("rst_busy", bus.busy, 64'h0);
      cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
      idle(5, 1'b0);
      chk("multu_hi", bus.hi, 64'h1);
      chk("multu_lo", bus.lo, 64'hFFFF_FFFE);
      cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
      idle(10, 1'b0);
      chk("div_lo", bus.lo, 64'hFFFF_FFFD);
      chk("div_hi", bus.hi, 64'hFFFF_FFFF);
      cycle(1'b1, 3'd3, 32'd7, 32'd0, 1'b0, 1'b1);
      idle(10, 1'b0);
      chk("divu0_lo", bus.lo, 64'hFFFF_FFFF);
      chk("divu0_hi", bus.hi, 64'h7);
      cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b1, 1'b1);
      idle(5, 1'b1);
      bus.start = 1'b0;
      bus.md_use = 1'b1;
      #1;
      chk("stall_after", bus.stall, 64'h0);
      cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b1);
      idle(6, 1'b0);
      cycle(1'b1, 3'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
      chk("mthi_busy", bus.busy, 64'h0);
      cycle(1'b1, 3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b1);
      chk("mthi_hi", bus.hi, 64'h1234_5678);
      chk("mtlo_lo", bus.lo, 64'h9ABC_DEF0);
      chk("mtlo_busy", bus.busy, 64'h0);
      cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b1);
      idle(3, 1'b0);
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      idle(12, 1'b0);
      chk("abort_hi", bus.hi, 64'h0);
      chk("abort_lo", bus.lo, 64'h0);
      chk("abort_busy", bus.busy, 64'h0);
      cycle(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      cycle(1'b1, 3'd0, 32'd5, 32'd6, 1'b0, 1'b1);
      idle(9, 1'b0);
      chk("ovf_lo", bus.lo, 64'h8000_0000);
      chk("ovf_hi", bus.hi, 64'h0);
      chk("ovf_busy", bus.busy, 64'h0);
      cycle(1'b1, 3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1);
      cycle(1'b1, 3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1);
      chk("rsvd_busy", bus.busy, 64'h0);
      repeat (3000)
         cycle($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), rnd_op(), rnd_op(),
               1'($urandom_range(0, 1)), $urandom_range(0, 99) != 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
